// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encodings,
// the bus error word and the pending-entry record.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hffff_ffff;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        rd;
    } bus_entry_t;

    // Round-robin winner: on a tie the master that was not granted last wins.
    function automatic logic rr_pick(input logic c0, input logic c1, input logic last);
        return (c0 && c1) ? ~last : c1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_req_latch.sv
// One pending request entry per master: captures a deferred request and
// drops it when the arbiter replays it onto the slave bus.
module arb_req_latch
    import mem_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] req_a,
    input  logic [31:0] req_d,
    input  logic        req_we,
    input  logic        req_rd,
    output bus_entry_t  entry
);

    logic        valid;
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
    logic        rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload carries no reset; it is only looked at while valid is set.
    always_ff @(posedge clk) begin
        if (capture) begin
            a  <= req_a;
            d  <= req_d;
            we <= req_we;
            rd <= req_rd;
        end
    end

    always_comb begin
        entry.valid = valid;
        entry.a     = a;
        entry.d     = d;
        entry.we    = we;
        entry.rd    = rd;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the pCPU memory bus with request latching/replay.
// Optional watchdog forcing a bus-error completion: define ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready,
    output logic        timeout
);

    arb_state_t  state;
    logic        last;
    logic [31:0] spo0_q, spo1_q;
    logic [31:0] own_a, own_d;
    logic        own_rd;
    bus_entry_t  pend0, pend1;

    logic req0, req1, acc0, acc1;
    logic grant0, grant1, replay0, replay1, cap0, cap1;
    logic done0, done1, rd0_done, rd1_done, expire, win, enter_busy;

    assign req0 = m0_rd || m0_we;
    assign req1 = m1_rd || m1_we;
    // A request from a master that already has one outstanding is ignored.
    assign acc0 = req0 && !pend0.valid && (state != BUSY0);
    assign acc1 = req1 && !pend1.valid && (state != BUSY1);

    always_comb begin
        s_a     = '0;
        s_d     = '0;
        s_we    = 1'b0;
        s_rd    = 1'b0;
        grant0  = 1'b0;
        grant1  = 1'b0;
        replay0 = 1'b0;
        replay1 = 1'b0;
        win     = 1'b0;
        case (state)
            IDLE: begin
                if (pend0.valid || pend1.valid) begin
                    win     = rr_pick(pend0.valid, pend1.valid, last);
                    replay0 = !win;
                    replay1 = win;
                    s_a     = win ? pend1.a  : pend0.a;
                    s_d     = win ? pend1.d  : pend0.d;
                    s_we    = win ? pend1.we : pend0.we;
                    s_rd    = win ? pend1.rd : pend0.rd;
                end else if (acc0 || acc1) begin
                    win    = rr_pick(acc0, acc1, last);
                    grant0 = !win;
                    grant1 = win;
                    s_a    = win ? m1_a  : m0_a;
                    s_d    = win ? m1_d  : m0_d;
                    s_we   = win ? m1_we : m0_we;
                    s_rd   = win ? m1_rd : m0_rd;
                end
            end
            BUSY0, BUSY1: begin
                s_a = own_a;
                s_d = own_d;
            end
            default: ;
        endcase
    end

    assign cap0 = acc0 && !grant0;
    assign cap1 = acc1 && !grant1;
    assign enter_busy = replay0 || replay1 || ((grant0 || grant1) && !s_ready);

    assign done0    = ((state == BUSY0) && (s_ready || expire)) || (grant0 && s_ready);
    assign done1    = ((state == BUSY1) && (s_ready || expire)) || (grant1 && s_ready);
    assign rd0_done = (state == BUSY0) ? own_rd : m0_rd;
    assign rd1_done = (state == BUSY1) ? own_rd : m1_rd;

    assign m0_ready = (state == BUSY0) ? (s_ready || expire) :
                      grant0           ? s_ready : !(pend0.valid || cap0);
    assign m1_ready = (state == BUSY1) ? (s_ready || expire) :
                      grant1           ? s_ready : !(pend1.valid || cap1);

    assign m0_spo = done0 ? (expire ? BUS_ERR_DATA : s_spo) : spo0_q;
    assign m1_spo = done1 ? (expire ? BUS_ERR_DATA : s_spo) : spo1_q;
    assign timeout = expire;

    arb_req_latch u_latch0 (
        .clk(clk), .rst(rst), .capture(cap0), .clear(replay0),
        .req_a(m0_a), .req_d(m0_d), .req_we(m0_we), .req_rd(m0_rd),
        .entry(pend0)
    );

    arb_req_latch u_latch1 (
        .clk(clk), .rst(rst), .capture(cap1), .clear(replay1),
        .req_a(m1_a), .req_d(m1_d), .req_we(m1_we), .req_rd(m1_rd),
        .entry(pend1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 1'b1;
            spo0_q <= '0;
            spo1_q <= '0;
        end else begin
            if (done0 && rd0_done) spo0_q <= m0_spo;
            if (done1 && rd1_done) spo1_q <= m1_spo;
            case (state)
                IDLE: begin
                    if (replay0 || (grant0 && !s_ready))      state <= BUSY0;
                    else if (replay1 || (grant1 && !s_ready)) state <= BUSY1;
                    if (replay0 || grant0)      last <= 1'b0;
                    else if (replay1 || grant1) last <= 1'b1;
                end
                BUSY0, BUSY1: begin
                    if (s_ready || expire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The slave address stays on the bus while a slow access is outstanding.
    always_ff @(posedge clk) begin
        if (enter_busy) begin
            own_a  <= s_a;
            own_d  <= s_d;
            own_rd <= s_rd;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign expire = (state != IDLE) && !s_ready && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if ((state != IDLE) && !s_ready && !expire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire = 1'b0;
`endif

endmodule
